// File: rtl/dm_mem_responder_downstream.sv
// Memory-side responder for the direct-mapped cache: fixed-latency line store.
// Define MEM_ACCUM_EN to make writes accumulate per 32-bit lane instead of overwriting.
package cache_def;
  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;
endpackage

module dm_mem_responder_downstream
  import cache_def::*;
#(
  parameter int LATENCY   = 4,
  parameter int IDX_W     = 14,
  parameter     INIT_FILE = ""
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, LAT, RESP} state_t;

  localparam logic [7:0] LAT_INIT = 8'(LATENCY - 1);

  state_t             state_q, state_n;
  logic [7:0]         cnt_q, cnt_n;
  logic [IDX_W-1:0]   idx_q;
  logic [127:0]       wdata_q;
  logic               rw_q;
  logic               cap;
  logic [127:0]       data_q;
  logic               ready_q;
  logic               busy_q;
  logic [127:0]       resp_w;
  logic               unused_addr;

  logic [127:0] store [2**IDX_W];

  initial begin
    for (int i = 0; i < 2**IDX_W; i++) store[i] = '0;
  end

  assign unused_addr = ^{mem_req.addr[31:IDX_W+4], mem_req.addr[3:0]};

`ifdef MEM_ACCUM_EN
  function automatic logic [127:0] lane_add(input logic [127:0] a,
                                            input logic [127:0] b);
    logic [127:0] r;
    for (int i = 0; i < 4; i++)
      r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
    return r;
  endfunction

  assign resp_w = lane_add(store[idx_q], wdata_q);
`else
  assign resp_w = wdata_q;
`endif

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: if (mem_req.valid) begin
        cap     = 1'b1;
        cnt_n   = LAT_INIT;
        state_n = LAT;
      end
      LAT: begin
        if (cnt_q == 8'd0) state_n = RESP;
        else               cnt_n   = cnt_q - 8'd1;
      end
      RESP: begin
        // only a write-back may chain straight into the next allocate
        if (rw_q && mem_req.valid) begin
          cap     = 1'b1;
          cnt_n   = LAT_INIT;
          state_n = LAT;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      busy_q  <= (state_n != IDLE);
      ready_q <= (state_n == RESP);
      if (cap) begin
        idx_q   <= mem_req.addr[IDX_W+3:4];
        wdata_q <= mem_req.data;
        rw_q    <= mem_req.rw;
      end
      if (state_q == LAT && state_n == RESP)
        data_q <= rw_q ? resp_w : store[idx_q];
    end
  end

  // the response register already holds the line to commit
  always_ff @(posedge clk) begin
    if (state_q == RESP && rw_q)
      store[idx_q] <= data_q;
  end

  assign mem_data.data  = data_q;
  assign mem_data.ready = ready_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_dm_mem_responder_downstream.sv
// Bench for dm_mem_responder_downstream: vector table, corner sequences, random traffic.
// Honours MEM_ACCUM_EN in its reference model.
module tb_dm_mem_responder_downstream;
  import cache_def::*;

  localparam int LATENCY = 4;
  localparam int IDX_W   = 14;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  mem_req_type  mem_req;
  mem_data_type mem_data;
  logic         busy;

  int compared = 0;
  int mismatched = 0;

  logic [127:0] model [int];

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  dm_mem_responder_downstream #(
    .LATENCY(LATENCY), .IDX_W(IDX_W), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req),
    .mem_data(mem_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] act,
                     input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'(a[IDX_W+3:4]);
  endfunction

  function automatic logic [127:0] peek(input logic [31:0] a);
    if (model.exists(line_of(a))) return model[line_of(a)];
    return '0;
  endfunction

  // reference: what a write leaves in the line (and echoes)
  function automatic logic [127:0] wr_result(input logic [31:0] a,
                                             input logic [127:0] d);
`ifdef MEM_ACCUM_EN
    logic [127:0] old, r;
    old = peek(a);
    for (int i = 0; i < 4; i++) r[32*i +: 32] = old[32*i +: 32] + d[32*i +: 32];
    return r;
`else
    return d;
`endif
  endfunction

  function automatic logic [127:0] apply(input logic [31:0] a,
                                         input logic [127:0] d, input logic rw);
    logic [127:0] r;
    if (!rw) return peek(a);
    r = wr_result(a, d);
    model[line_of(a)] = r;
    return r;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [127:0] d,
                       input logic rw);
    mem_req.addr  = a;
    mem_req.data  = d;
    mem_req.rw    = rw;
    mem_req.valid = 1'b1;
  endtask

  // called at the negedge right after the accepting posedge
  task automatic wait_ready(input string n, input logic [127:0] exp);
    int k = 1;
    while (!mem_data.ready && k < 40) begin
      chk({n, "_busy"}, 128'(busy), 128'd1);
      @(negedge clk);
      k++;
    end
    chk({n, "_lat"}, 128'(k), 128'(LATENCY + 1));
    chk({n, "_data"}, mem_data.data, exp);
    chk({n, "_busyresp"}, 128'(busy), 128'd1);
  endtask

  task automatic run_req(input string n, input logic [31:0] a,
                         input logic [127:0] d, input logic rw,
                         input logic [127:0] exp);
    @(negedge clk);
    drive(a, d, rw);
    @(negedge clk);
    mem_req.valid = 1'b0;
    wait_ready(n, exp);
    @(negedge clk);
    chk({n, "_pulse"}, 128'(mem_data.ready), 128'd0);
    chk({n, "_idle"}, 128'(busy), 128'd0);
  endtask

  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_DEAD_BEEF_CAFE_F00D;
  localparam logic [127:0] D2 = 128'hFEDC_BA98_7654_3210_0F0F_0F0F_A5A5_5A5A;

  initial begin
    logic [127:0] e, pre;
    logic [31:0]  a;
    logic [127:0] d;
    logic         rw;
    int           seen;

    vecs[0] = '{32'h0000_0010, 128'h0,   1'b0, 128'h0};
    vecs[1] = '{32'h0000_0020, D1,       1'b1, D1};
    vecs[2] = '{32'h0000_0020, 128'h0,   1'b0, D1};
    vecs[3] = '{32'h0004_002C, 128'h0,   1'b0, D1};
    vecs[4] = '{32'h0000_1230, D2,       1'b1, D2};
    vecs[5] = '{32'hFFFC_1237, 128'h0,   1'b0, D2};

    mem_req = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(mem_data.ready), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_data", mem_data.data, 128'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      void'(apply(vecs[i].addr, vecs[i].data, vecs[i].rw));
      run_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data,
              vecs[i].rw, vecs[i].exp);
    end

    // write-back chained into allocate with no idle gap
    @(negedge clk);
    drive(32'h100, D2, 1'b1);
    e = apply(32'h100, D2, 1'b1);
    @(negedge clk);
    mem_req.valid = 1'b0;
    wait_ready("chain_wr", e);
    drive(32'h200, 128'h0, 1'b0);
    @(negedge clk);
    mem_req.valid = 1'b0;
    chk("chain_nogap", 128'(busy), 128'd1);
    wait_ready("chain_rd", peek(32'h200));
    @(negedge clk);
    chk("chain_idle", 128'(busy), 128'd0);

    // valid during LAT and during a read's RESP is ignored
    @(negedge clk);
    drive(32'h10, 128'h0, 1'b0);
    @(negedge clk);
    mem_req.valid = 1'b0;
    @(negedge clk);
    drive(32'h20, 128'h0, 1'b0);
    @(negedge clk);
    mem_req.valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (mem_data.ready) begin
        seen++;
        if (seen == 1) begin
          chk("ign_data", mem_data.data, peek(32'h10));
          drive(32'h20, 128'h0, 1'b0);
        end
      end else begin
        mem_req.valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("ign_pulses", 128'(seen), 128'd1);
    chk("ign_idle", 128'(busy), 128'd0);

    // reset mid-LAT abandons the write
    pre = peek(32'h40);
    @(negedge clk);
    drive(32'h40, D1 ^ D2, 1'b1);
    @(negedge clk);
    mem_req.valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_ready", 128'(mem_data.ready), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    run_req("arst_rd", 32'h40, 128'h0, 1'b0, pre);

`ifdef MEM_ACCUM_EN
    run_req("acc_w1", 32'h30, {4{32'h5}}, 1'b1, {4{32'h5}});
    void'(apply(32'h30, {4{32'h5}}, 1'b1));
    run_req("acc_w2", 32'h30, {4{32'h5}}, 1'b1, {4{32'hA}});
    void'(apply(32'h30, {4{32'h5}}, 1'b1));
    run_req("acc_rd", 32'h30, 128'h0, 1'b0, {4{32'hA}});
    run_req("wrap_w1", 32'h3000, {4{32'h1}}, 1'b1, {4{32'h1}});
    void'(apply(32'h3000, {4{32'h1}}, 1'b1));
    run_req("wrap_w2", 32'h3000, {96'h0, 32'hFFFF_FFFF}, 1'b1,
            {{3{32'h1}}, 32'h0});
    void'(apply(32'h3000, {96'h0, 32'hFFFF_FFFF}, 1'b1));
    run_req("wrap_rd", 32'h3000, 128'h0, 1'b0, {{3{32'h1}}, 32'h0});
`endif

    for (int i = 0; i < 40; i++) begin
      a  = {$urandom_range(0, 15)} << (IDX_W + 4);
      a  = a | (32'($urandom_range(0, 7)) << 9) | 32'($urandom_range(0, 15));
      d  = {$urandom, $urandom, $urandom, $urandom};
      rw = 1'($urandom_range(0, 1));
      e  = apply(a, d, rw);
      run_req($sformatf("rnd%0d", i), a, d, rw, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
